// File: rtl/regfile_pkg.sv
// Shared register file constants and the write-request record used by the
// writeback arbitration logic.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer; the pointer advances past each winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    idx      = '0;
    if (en && !rst) begin
      for (int k = N - 1; k >= 0; k--) begin
        idx = PW'((int'(ptr) + k) % N);
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          ptr_next = PW'((int'(ptr) + k + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among several writeback sources and
// exposes the in-flight write for read bypass.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      hold,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         WriteReg,
  output logic [DATA_W-1:0]         WriteData,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      rd_hit1,
  output logic                      rd_hit2,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [NUM_REQ-1:0] gnt;
  logic               fire;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_zero;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (!hold),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign fire      = |gnt;

  // Grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_zero = (sel_addr == ZERO_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (fire) begin
      RegWrite  <= !sel_zero;
      WriteReg  <= sel_addr;
      WriteData <= sel_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Writes to the hardwired zero register complete but are counted as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (fire && sel_zero && (drop_cnt != CNT_MAX)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign rd_hit1 = RegWrite && (WriteReg == rd_addr1) && (rd_addr1 != ZERO_ADDR);
  assign rd_hit2 = RegWrite && (WriteReg == rd_addr2) && (rd_addr2 != ZERO_ADDR);

endmodule
